// File: rtl/fpdsp_pkg.sv
// Shared types and DSP48E1 control constants for the iterative FP sequencer.
//   state_t : sequencer states
//   op_t    : operation codes as presented on the operation port
//   OPM_*/ALU_*/INM_* : DSP48E1 control words driven on each pass
package fpdsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ALIGN = 3'd2,
        ST_ARITH = 3'd3,
        ST_RND   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    localparam logic [6:0] OPM_NONE = 7'b0000000;
    localparam logic [6:0] OPM_MUL  = 7'b0000101;  // A*B (align shift done as a multiply)
    localparam logic [6:0] OPM_CADD = 7'b0110011;  // C + A:B
    localparam logic [6:0] OPM_RND  = 7'b0100010;  // P + P-path, carry-in adds the round bit

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0011;

    localparam logic [4:0] INM_DEF  = 5'b00000;

    // True for the single-cycle states that clock the DSP.
    function automatic logic is_issue(input state_t s);
        return (s == ST_ALIGN) || (s == ST_ARITH) || (s == ST_RND);
    endfunction

endpackage

// File: rtl/fpdsp_wait_ctr.sv
// Loadable down-counter that times out the DSP pipeline after each issue.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : load load_val_i (takes priority over dec_i)
//   dec_i       : decrement by one, holding at zero
//   load_val_i  : value loaded on load_i
//   zero_c      : combinational flag, counter equals zero
module fpdsp_wait_ctr #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_c
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/fpdsp_seq_ctrl.sv
// Micro-sequencer for the single-DSP48E1 floating-point add/sub/mul unit.
// Steps the DSP through align, arithmetic and round passes, waiting out the
// pipeline after each, then pulses result_valid with the result-mux select.
//   clk, rst      : clock, synchronous active-high reset
//   run           : start request, accepted only while ready
//   operation     : 00 add, 01 sub, 10 mul, 11 illegal
//   shift_det     : prealign says an align pass is needed (add/sub only)
//   input_exc     : prealign exception flags, non-zero forces early exit
//   round_up      : round decision, sampled on the last wait before RND
//   opmode/alumode/inmode/carryin : DSP48E1 control words
//   ce_dsp        : DSP clock enable, high on issue cycles only
//   res_load      : 1 selects DSP result, 0 the forwarded/exception path
//   ready, busy   : idle-and-accepting / operation in flight
//   result_valid  : one-cycle completion pulse
//   illegal_op    : pulses with result_valid for operation 11
module fpdsp_seq_ctrl
    import fpdsp_pkg::*;
#(
    parameter int unsigned DSP_LAT = 3,
    parameter int unsigned EXC_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [1:0]       operation,
    input  logic             shift_det,
    input  logic [EXC_W-1:0] input_exc,
    input  logic             round_up,
    output logic [6:0]       opmode,
    output logic [3:0]       alumode,
    output logic [4:0]       inmode,
    output logic             carryin,
    output logic             ce_dsp,
    output logic             res_load,
    output logic             ready,
    output logic             busy,
    output logic             result_valid,
    output logic             illegal_op
);

    localparam int unsigned CNT_W = $clog2(DSP_LAT + 1);

    state_t     state_q, state_d;
    state_t     pass_q,  pass_d;     // pass to enter when the current wait expires
    op_t        op_q,    op_d;
    logic       exc_q,   exc_d;      // early-exit path taken for this operation

    logic [6:0] opmode_q,  opmode_d;
    logic [3:0] alumode_q, alumode_d;
    logic [4:0] inmode_q,  inmode_d;
    logic       carryin_q, carryin_d;
    logic       ce_q,      ce_d;
    logic       res_load_q, res_load_d;
    logic       ready_q,   ready_d;
    logic       busy_q,    busy_d;
    logic       valid_q,   valid_d;
    logic       ill_q,     ill_d;

    logic       ctr_load;
    logic       ctr_dec;
    logic       ctr_zero_c;

    fpdsp_wait_ctr #(
        .WIDTH (CNT_W)
    ) u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load),
        .dec_i      (ctr_dec),
        .load_val_i (CNT_W'(DSP_LAT - 1)),
        .zero_c     (ctr_zero_c)
    );

    // Next-state logic, then registered outputs decoded from the next state so
    // every output lines up with the state it belongs to.
    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        op_d       = op_q;
        exc_d      = exc_q;
        opmode_d   = opmode_q;
        alumode_d  = alumode_q;
        inmode_d   = inmode_q;
        carryin_d  = carryin_q;
        ce_d       = 1'b0;
        res_load_d = 1'b0;
        valid_d    = 1'b0;
        ill_d      = 1'b0;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    op_d    = op_t'(operation);
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                if ((input_exc != '0) || (op_q == OP_ILL)) begin
                    exc_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    exc_d   = 1'b0;
                    state_d = ((op_q != OP_MUL) && shift_det) ? ST_ALIGN : ST_ARITH;
                end
            end
            ST_ALIGN: begin
                ctr_load = 1'b1;
                pass_d   = ST_ARITH;
                state_d  = ST_WAIT;
            end
            ST_ARITH: begin
                ctr_load = 1'b1;
                pass_d   = ST_RND;
                state_d  = ST_WAIT;
            end
            ST_RND: begin
                ctr_load = 1'b1;
                pass_d   = ST_DONE;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (ctr_zero_c) begin
                    state_d = pass_q;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output decode for the state being entered.
        unique case (state_d)
            ST_ALIGN: begin
                ce_d      = 1'b1;
                opmode_d  = OPM_MUL;
                alumode_d = ALU_ADD;
                inmode_d  = INM_DEF;
                carryin_d = 1'b0;
            end
            ST_ARITH: begin
                ce_d      = 1'b1;
                opmode_d  = (op_q == OP_MUL) ? OPM_MUL : OPM_CADD;
                alumode_d = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
                inmode_d  = INM_DEF;
                carryin_d = 1'b0;
            end
            ST_RND: begin
                // Entered only from the last wait cycle, so round_up is sampled there.
                ce_d      = 1'b1;
                opmode_d  = OPM_RND;
                alumode_d = ALU_ADD;
                inmode_d  = INM_DEF;
                carryin_d = round_up;
            end
            ST_DONE: begin
                valid_d    = 1'b1;
                res_load_d = ~exc_d;
                ill_d      = (op_q == OP_ILL);
            end
            default: begin
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pass_q     <= ST_IDLE;
            op_q       <= OP_ADD;
            exc_q      <= 1'b0;
            opmode_q   <= OPM_NONE;
            alumode_q  <= ALU_ADD;
            inmode_q   <= INM_DEF;
            carryin_q  <= 1'b0;
            ce_q       <= 1'b0;
            res_load_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            op_q       <= op_d;
            exc_q      <= exc_d;
            opmode_q   <= opmode_d;
            alumode_q  <= alumode_d;
            inmode_q   <= inmode_d;
            carryin_q  <= carryin_d;
            ce_q       <= ce_d;
            res_load_q <= res_load_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            ill_q      <= ill_d;
        end
    end

    assign opmode       = opmode_q;
    assign alumode      = alumode_q;
    assign inmode       = inmode_q;
    assign carryin      = carryin_q;
    assign ce_dsp       = ce_q;
    assign res_load     = res_load_q;
    assign ready        = ready_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign illegal_op   = ill_q;

endmodule

// File: tb/tb_fpdsp_seq_ctrl.sv
// Directed bench for fpdsp_seq_ctrl with DSP_LAT=3. Inputs change and outputs
// are sampled on the falling edge; cycle c is the value captured by edge c
// counted from the run-accept edge (edge 0).
module tb_fpdsp_seq_ctrl;

    localparam logic [6:0] E_OPM_MUL  = 7'b0000101;
    localparam logic [6:0] E_OPM_CADD = 7'b0110011;
    localparam logic [6:0] E_OPM_RND  = 7'b0100010;

    logic       clk;
    logic       rst;
    logic       run;
    logic [1:0] operation;
    logic       shift_det;
    logic [3:0] input_exc;
    logic       round_up;
    logic [6:0] opmode;
    logic [3:0] alumode;
    logic [4:0] inmode;
    logic       carryin;
    logic       ce_dsp;
    logic       res_load;
    logic       ready;
    logic       busy;
    logic       result_valid;
    logic       illegal_op;

    int n_vec;
    int n_err;

    fpdsp_seq_ctrl #(
        .DSP_LAT (3),
        .EXC_W   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .operation    (operation),
        .shift_det    (shift_det),
        .input_exc    (input_exc),
        .round_up     (round_up),
        .opmode       (opmode),
        .alumode      (alumode),
        .inmode       (inmode),
        .carryin      (carryin),
        .ce_dsp       (ce_dsp),
        .res_load     (res_load),
        .ready        (ready),
        .busy         (busy),
        .result_valid (result_valid),
        .illegal_op   (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation from accept to the cycle after DONE. e0..e2 are the issue
    // cycles (0 = unused) with their expected opmode/alumode; lat is the DONE cycle.
    task automatic run_op(input string name, input logic [1:0] op, input logic sh,
                          input logic [3:0] exc, input logic ru, input int lat,
                          input int e0, input int e1, input int e2,
                          input logic [6:0] om0, input logic [6:0] om1, input logic [6:0] om2,
                          input logic [3:0] am0, input logic [3:0] am1, input logic [3:0] am2,
                          input logic exp_rl, input logic exp_ill);
        logic       is_iss;
        logic [6:0] om_e;
        logic [3:0] am_e;
        @(negedge clk);
        operation = op;
        shift_det = sh;
        input_exc = exc;
        round_up  = ru;
        run       = 1'b1;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            // Inputs past their sampling cycle are scrambled; they must not matter.
            if (c == 1) begin
                run       = 1'b0;
                operation = ~op;
            end
            if (c == 2) begin
                shift_det = ~sh;
                input_exc = 4'hF;
            end
            is_iss = 1'b0;
            om_e   = 7'd0;
            am_e   = 4'd0;
            if (c == e0) begin is_iss = 1'b1; om_e = om0; am_e = am0; end
            else if (c == e1) begin is_iss = 1'b1; om_e = om1; am_e = am1; end
            else if (c == e2) begin is_iss = 1'b1; om_e = om2; am_e = am2; end
            chk($sformatf("%s.ce@%0d", name, c), 32'(ce_dsp), 32'(is_iss));
            if (is_iss) begin
                chk($sformatf("%s.opmode@%0d", name, c), 32'(opmode), 32'(om_e));
                chk($sformatf("%s.alumode@%0d", name, c), 32'(alumode), 32'(am_e));
                chk($sformatf("%s.inmode@%0d", name, c), 32'(inmode), 32'd0);
                chk($sformatf("%s.carryin@%0d", name, c), 32'(carryin),
                    32'((om_e == E_OPM_RND) ? ru : 1'b0));
            end
            if (c <= lat) begin
                chk($sformatf("%s.valid@%0d", name, c), 32'(result_valid), 32'(c == lat));
                chk($sformatf("%s.busy@%0d", name, c), 32'(busy), 32'(c < lat));
                chk($sformatf("%s.ready@%0d", name, c), 32'(ready), 32'd0);
            end
            if (c == lat) begin
                chk($sformatf("%s.res_load", name), 32'(res_load), 32'(exp_rl));
                chk($sformatf("%s.illegal", name), 32'(illegal_op), 32'(exp_ill));
            end
            if (c == lat + 1) begin
                chk($sformatf("%s.ready_after", name), 32'(ready), 32'd1);
                chk($sformatf("%s.valid_after", name), 32'(result_valid), 32'd0);
                chk($sformatf("%s.illegal_after", name), 32'(illegal_op), 32'd0);
            end
        end
    endtask

    initial begin
        int first_rv;
        int second_rv;
        int rv_cnt;
        logic rdy14;
        logic rdy15;

        n_vec     = 0;
        n_err     = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        run       = 1'b0;
        operation = 2'b00;
        shift_det = 1'b0;
        input_exc = 4'h0;
        round_up  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(result_valid), 32'd0);
        chk("rst.ce", 32'(ce_dsp), 32'd0);
        chk("rst.opmode", 32'(opmode), 32'd0);
        chk("rst.alumode", 32'(alumode), 32'd0);
        chk("rst.inmode", 32'(inmode), 32'd0);
        chk("rst.carryin", 32'(carryin), 32'd0);
        chk("rst.res_load", 32'(res_load), 32'd0);
        chk("rst.illegal", 32'(illegal_op), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Add with shift: issues at 2/6/10, done at 14
        run_op("add_sh", 2'b00, 1'b1, 4'h0, 1'b0, 14, 2, 6, 10,
               E_OPM_MUL, E_OPM_CADD, E_OPM_RND, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

        // Sub without shift: ALU_SUB on ARITH, done at 10
        run_op("sub", 2'b01, 1'b0, 4'h0, 1'b0, 10, 2, 6, 0,
               E_OPM_CADD, E_OPM_RND, 7'd0, 4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b0);

        // Mul ignores shift_det; round_up=1 gives carryin on RND at 6
        run_op("mul", 2'b10, 1'b1, 4'h0, 1'b1, 10, 2, 6, 0,
               E_OPM_MUL, E_OPM_RND, 7'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

        // Input exception: straight to DONE at 2, forwarded path
        run_op("exc", 2'b00, 1'b1, 4'b0010, 1'b0, 2, 0, 0, 0,
               7'd0, 7'd0, 7'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Reset mid-ARITH: aborted op leaves nothing behind
        @(negedge clk);
        operation = 2'b00;
        shift_det = 1'b0;
        input_exc = 4'h0;
        run       = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk("abort.ce_arith", 32'(ce_dsp), 32'd1);
        chk("abort.opmode_arith", 32'(opmode), 32'(E_OPM_CADD));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.ready", 32'(ready), 32'd1);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.opmode", 32'(opmode), 32'd0);
        chk("abort.ce", 32'(ce_dsp), 32'd0);
        rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid) rv_cnt++;
        end
        chk("abort.no_valid", 32'(rv_cnt), 32'd0);

        // Illegal op: valid and illegal_op together at 2
        run_op("ill", 2'b11, 1'b0, 4'h0, 1'b0, 2, 0, 0, 0,
               7'd0, 7'd0, 7'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);

        // run held high: second accept only once ready returns
        @(negedge clk);
        operation = 2'b00;
        shift_det = 1'b1;
        input_exc = 4'h0;
        round_up  = 1'b0;
        run       = 1'b1;
        first_rv  = -1;
        second_rv = -1;
        rdy14     = 1'b1;
        rdy15     = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (result_valid) begin
                if (first_rv < 0) first_rv = c;
                else if (second_rv < 0) second_rv = c;
            end
            if (c == 14) rdy14 = ready;
            if (c == 15) rdy15 = ready;
            if (c == 16) run = 1'b0;
        end
        chk("busy.first_valid", 32'(first_rv), 32'd14);
        chk("busy.no_ready_in_done", 32'(rdy14), 32'd0);
        chk("busy.ready_after_done", 32'(rdy15), 32'd1);
        chk("busy.second_valid", 32'(second_rv), 32'd29);
        chk("busy.gap", 32'(second_rv - first_rv), 32'd15);
        chk("busy.idle_end", 32'(ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
